note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Song-level controller that feeds note_player one note at a time.
- Fetches {note, duration} words from an external synchronous song ROM, presents them to note_player with a one-cycle load_new_note strobe, and waits for done_with_note before advancing.
- Handles play/pause, song restart and end-of-song detection.
- Sits between the top-level MCU/button logic and note_player.

Parameters:
- SONG_BITS, 2, song-select width (4 songs).
- IDX_BITS, 5, note-index width (32 note slots per song).
- NOTE_W, 6, note-number width.
- DUR_W, 6, duration width in 48ths of a beat.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  1 = advance through song, 0 = hold (pause)
- song  in  SONG_BITS  song select, captured on leaving IDLE
- new_song  in  1  one-cycle pulse: abort current song, restart at index 0
- rom_addr  out  SONG_BITS+IDX_BITS  {song_latched, note_index} to song ROM
- rom_data  in  NOTE_W+DUR_W  {note[11:6], duration[5:0]}, valid 1 cycle after rom_addr
- note_to_load  out  NOTE_W  registered note for note_player
- duration_to_load  out  DUR_W  registered duration for note_player
- load_new_note  out  1  one-cycle strobe to note_player
- done_with_note  in  1  note_player finished current note
- song_done  out  1  one-cycle pulse at end of song
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, note_index=0, song_latched=0, note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0, busy=0.
- rom_addr = {song_latched, note_index}, driven from registers at all times.
- States and transitions:
  - IDLE: if play=1, latch song and go to FETCH.
  - FETCH: address presented; always go to LATCH.
  - LATCH: rom_data valid; register note and duration into note_to_load/duration_to_load. If duration==0 (end marker), go to DONE; else go to LOAD.
  - LOAD: load_new_note=1 for exactly this cycle; go to WAIT.
  - WAIT: hold until done_with_note=1. Then:
    - if note_index==all-ones, go to DONE;
    - else increment note_index and go to FETCH if play=1, or PAUSE if play=0.
  - PAUSE: go to FETCH when play=1.
  - DONE: song_done=1 for this cycle; note_index<=0; go to IDLE.
- Pause handling:
  - play=0 does not interrupt WAIT. note_player pauses itself via its play_enable, and done_with_note is still honoured.
  - play=0 in FETCH/LATCH/LOAD does not stall; the in-flight note is still loaded.
- Latency: play sampled high in IDLE at edge N gives load_new_note high during the cycle after edge N+3 (IDLE→FETCH→LATCH→LOAD).
  - Note-to-note gap: done_with_note seen at edge M gives the next load_new_note in the cycle after edge M+3.
- Rests: note value 0 with nonzero duration is loaded normally; note_player outputs silence.
- new_song pulse, from any state including mid-WAIT:
  - note_index<=0, load_new_note<=0, no song_done.
  - If play=1: song_latched<=song and go to FETCH. Otherwise go to IDLE.
  - new_song takes priority over done_with_note and over the end-marker check in the same cycle.
- Ignored inputs:
  - done_with_note outside WAIT is ignored.
  - song changes outside IDLE/new_song are ignored.
- Index wrap: the index never wraps silently; slot 31 completing always ends the song.

Decomposition:
- Shared package (music_pkg): NOTE_W, DUR_W, SONG_BITS, IDX_BITS, ROM word field offsets, END_MARKER duration=0, state enum encoding.
- No sub-module required. The song ROM is external, so one ROM model can be shared with the top level and the bench.

Test Plan:
- Basic sequence: song 0 ROM = {44,6},{45,4},{0,3},{x,0}; play=1; bench done_with_note model 5 cycles after each load. Required: three load_new_note pulses carrying (44,6), (45,4), (0,3); rom_addr 0,1,2,3; song_done one pulse after the marker; busy=0 after.
- Latency: play rises in IDLE. Required: load_new_note exactly 3 cycles after the sampling edge, and 3 cycles after each done_with_note.
- Pause: drop play during WAIT of note 1. Required: done_with_note still accepted, FSM parks in PAUSE with rom_addr=1 and no load. Raise play: note (45,4) loaded 3 cycles later.
- new_song mid-note: during WAIT of index 2, song=1, pulse new_song with play=1. Required: no song_done, rom_addr jumps to {1,0}, next load carries song 1 word 0.
- Full song: 32 nonzero entries. Required: 32 loads, song_done after index 31, note_index returns to 0.
- Async reset mid-WAIT (not clock-aligned). Required: all outputs 0 immediately, state IDLE; subsequent play restarts at index 0.

Source files
------------

// File: rtl/music_pkg.sv
// Purpose: shared widths, ROM word layout and FSM encoding for the song sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package music_pkg;

    // Default geometry: 4 songs x 32 note slots, 6-bit notes, 6-bit durations (48ths of a beat)
    localparam int DEF_SONG_BITS = 2;
    localparam int DEF_IDX_BITS  = 5;
    localparam int DEF_NOTE_W    = 6;
    localparam int DEF_DUR_W     = 6;

    // ROM word layout: {note, duration}, duration in the low bits
    localparam int DUR_LSB  = 0;
    localparam int NOTE_LSB = DEF_DUR_W;
    localparam int ROM_W    = DEF_NOTE_W + DEF_DUR_W;

    // A zero duration terminates a song before slot 31
    localparam logic [DEF_DUR_W-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PAUSE = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/note_sequencer.sv
// Purpose: walks a song ROM and hands {note, duration} to note_player one note at a time.
// Latency: play seen in IDLE (or done_with_note seen in WAIT) -> load_new_note 3 cycles later.
// Backpressure: holds in WAIT until done_with_note; play=0 parks in PAUSE between notes only.
module note_sequencer
    import music_pkg::*;
#(
    parameter int SONG_BITS = DEF_SONG_BITS,
    parameter int IDX_BITS  = DEF_IDX_BITS,
    parameter int NOTE_W    = DEF_NOTE_W,
    parameter int DUR_W     = DEF_DUR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          new_song,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_data,
    output logic [NOTE_W-1:0]             note_to_load,
    output logic [DUR_W-1:0]              duration_to_load,
    output logic                          load_new_note,
    input  logic                          done_with_note,
    output logic                          song_done,
    output logic                          busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

    seq_state_t             state;
    logic [SONG_BITS-1:0]   song_latched;
    logic [IDX_BITS-1:0]    note_index;
    logic [NOTE_W-1:0]      rom_note;
    logic [DUR_W-1:0]       rom_dur;

    // Split the ROM word into its fields
    assign rom_dur  = rom_data[0 +: DUR_W];
    assign rom_note = rom_data[DUR_W +: NOTE_W];

    // The ROM address always comes straight from the song/index registers
    assign rom_addr = {song_latched, note_index};
    assign busy     = (state != ST_IDLE);

    // Song-walking FSM; strobes are registered and default low every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            song_latched     <= '0;
            note_index       <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            load_new_note <= 1'b0;
            song_done     <= 1'b0;
            if (new_song) begin
                // Restart wins over everything else, including a pending done or end marker
                note_index <= '0;
                if (play) begin
                    song_latched <= song;
                    state        <= ST_FETCH;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (play) begin
                            song_latched <= song;
                            state        <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // ROM registers the address on this edge
                        state <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        note_to_load     <= rom_note;
                        duration_to_load <= rom_dur;
                        state            <= (rom_dur == END_MARKER) ? ST_DONE : ST_LOAD;
                    end
                    ST_LOAD: begin
                        load_new_note <= 1'b1;
                        state         <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // play=0 never interrupts a sounding note; note_player pauses itself
                        if (done_with_note) begin
                            if (note_index == LAST_IDX) begin
                                state <= ST_DONE;
                            end else begin
                                note_index <= note_index + 1'b1;
                                state      <= play ? ST_FETCH : ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (play) begin
                            state <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        song_done  <= 1'b1;
                        note_index <= '0;
                        state      <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
    import music_pkg::*;

    localparam int SB    = DEF_SONG_BITS;
    localparam int IB    = DEF_IDX_BITS;
    localparam int NW    = DEF_NOTE_W;
    localparam int DW    = DEF_DUR_W;
    localparam int AW    = SB + IB;
    localparam int RW    = NW + DW;
    localparam int SLOTS = 1 << IB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          play = 1'b0;
    logic [SB-1:0] song = '0;
    logic          new_song = 1'b0;
    logic          done_with_note = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [RW-1:0] rom_data;
    logic [NW-1:0] note_to_load;
    logic [DW-1:0] duration_to_load;
    logic          load_new_note;
    logic          song_done;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    note_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .new_song         (new_song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .done_with_note   (done_with_note),
        .song_done        (song_done),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous song ROM: data valid the cycle after the address
    logic [RW-1:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Monitor: log every load strobe and song_done pulse with the edge that raised it
    int            ld_cyc_q[$];
    logic [NW-1:0] ld_note_q[$];
    logic [DW-1:0] ld_dur_q[$];
    logic [AW-1:0] ld_addr_q[$];
    int            sd_cyc_q[$];
    always @(negedge clk) begin
        if (load_new_note === 1'b1) begin
            ld_cyc_q.push_back(cyc);
            ld_note_q.push_back(note_to_load);
            ld_dur_q.push_back(duration_to_load);
            ld_addr_q.push_back(rom_addr);
        end
        if (song_done === 1'b1) sd_cyc_q.push_back(cyc);
    end

    // note_player stand-in: pulses done_with_note a delay after each load
    int done_dly   = 5;
    bit rand_dly   = 1'b0;
    int cancel_gen = 0;
    int done_cyc_q[$];
    initial begin
        int pend;
        int seen_gen;
        pend = 0;
        seen_gen = 0;
        forever begin
            @(negedge clk);
            #1;
            done_with_note = 1'b0;
            if (cancel_gen != seen_gen) begin
                pend = 0;
                seen_gen = cancel_gen;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    done_with_note = 1'b1;
                    done_cyc_q.push_back(cyc + 1);
                end
            end
            if (load_new_note === 1'b1) pend = rand_dly ? int'($urandom_range(3, 9)) : done_dly;
        end
    end

    // Reference model: the notes a song plays, straight from the ROM contents
    logic [NW-1:0] ex_note[$];
    logic [DW-1:0] ex_dur[$];
    logic [IB-1:0] ex_idx[$];
    function automatic void build_expected(input int s);
        logic [RW-1:0] w;
        ex_note.delete();
        ex_dur.delete();
        ex_idx.delete();
        for (int i = 0; i < SLOTS; i++) begin
            w = rom[s * SLOTS + i];
            if (w[DW-1:0] == 0) break;
            ex_note.push_back(w[RW-1:DW]);
            ex_dur.push_back(w[DW-1:0]);
            ex_idx.push_back(IB'(i));
        end
    endfunction

    function automatic logic [RW-1:0] rand_word();
        return {NW'($urandom), DW'($urandom_range(1, (1 << DW) - 1))};
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_loads(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (ld_cyc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_to_done(input int sd_base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sd_cyc_q.size() > sd_base) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        play = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        play = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({load_new_note, song_done, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got load/done/busy=%b required 000", {load_new_note, song_done, busy});
        end
        n_checks++;
        if ({rom_addr, note_to_load, duration_to_load} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got addr=%0h note=%0d dur=%0d required all 0", rom_addr, note_to_load, duration_to_load);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int b, sb, db, ps;
        bit ok;
        b = ld_cyc_q.size(); sb = sd_cyc_q.size(); db = done_cyc_q.size();
        build_expected(0);
        song = 0;
        play = 1'b1;
        ps = cyc + 1;
        run_to_done(sb, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: no song_done within budget"); end
        n_checks++;
        if (ld_cyc_q.size() - b !== 3 || ex_note.size() !== 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d loads required 3 (model %0d)", ld_cyc_q.size() - b, ex_note.size());
        end
        for (int k = 0; k < ex_note.size(); k++) begin
            n_checks++;
            if (ld_note_q[b+k] !== ex_note[k] || ld_dur_q[b+k] !== ex_dur[k] || ld_addr_q[b+k] !== {SB'(0), ex_idx[k]}) begin
                n_fail++;
                $display("FAIL basic_load%0d: got (%0d,%0d)@%0h required (%0d,%0d)@%0h", k, ld_note_q[b+k], ld_dur_q[b+k],
                         ld_addr_q[b+k], ex_note[k], ex_dur[k], {SB'(0), ex_idx[k]});
            end
            n_checks++;
            if (k == 0) begin
                if (ld_cyc_q[b] !== ps + 3) begin
                    n_fail++;
                    $display("FAIL basic_latency_play: load at edge %0d required %0d", ld_cyc_q[b], ps + 3);
                end
            end else if (ld_cyc_q[b+k] !== done_cyc_q[db+k-1] + 3) begin
                n_fail++;
                $display("FAIL basic_latency_gap%0d: load at edge %0d required %0d", k, ld_cyc_q[b+k], done_cyc_q[db+k-1] + 3);
            end
        end
        tick();
        n_checks++;
        if (sd_cyc_q.size() - sb !== 1 || busy !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL basic_end: got song_done x%0d busy=%b addr=%0h required x1 0 0", sd_cyc_q.size() - sb, busy, rom_addr);
        end
    endtask

    task automatic test_pause();
        int b, sb, db, pc;
        bit ok;
        logic [AW-1:0] exp_a;
        b = ld_cyc_q.size(); sb = sd_cyc_q.size(); db = done_cyc_q.size();
        build_expected(0);
        song = 0;
        play = 1'b1;
        wait_loads(b + 1, 50, ok);
        play = 1'b0;
        for (int i = 0; i < 50 && done_cyc_q.size() == db; i++) tick();
        repeat (4) tick();
        exp_a = {SB'(0), IB'(1)};
        n_checks++;
        if (rom_addr !== exp_a || busy !== 1'b1 || ld_cyc_q.size() !== b + 1 || done_cyc_q.size() !== db + 1) begin
            n_fail++;
            $display("FAIL pause_park: got addr=%0h busy=%b loads=%0d dones=%0d required addr=%0h busy=1 loads=%0d dones=%0d",
                     rom_addr, busy, ld_cyc_q.size() - b, done_cyc_q.size() - db, exp_a, 1, 1);
        end
        play = 1'b1;
        pc = cyc + 1;
        wait_loads(b + 2, 50, ok);
        n_checks++;
        if (!ok || ld_cyc_q[b+1] !== pc + 3 || ld_note_q[b+1] !== ex_note[1] || ld_dur_q[b+1] !== ex_dur[1]) begin
            n_fail++;
            $display("FAIL pause_resume: got (%0d,%0d) at edge %0d required (%0d,%0d) at %0d", ld_note_q[b+1], ld_dur_q[b+1],
                     ld_cyc_q[b+1], ex_note[1], ex_dur[1], pc + 3);
        end
        run_to_done(sb, 400, ok);
        n_checks++;
        if (!ok || ld_cyc_q.size() - b !== ex_note.size() || ld_note_q[b+2] !== ex_note[2]) begin
            n_fail++;
            $display("FAIL pause_finish: got %0d loads done=%b required %0d", ld_cyc_q.size() - b, ok, ex_note.size());
        end
        tick();
    endtask

    task automatic test_new_song();
        int b, sb, l, n1;
        bit ok;
        logic [AW-1:0] exp_a;
        n1 = $urandom_range(1, 6);
        for (int i = 0; i < SLOTS; i++) rom[SLOTS + i] = (i < n1) ? rand_word() : {NW'($urandom), DW'(0)};
        b = ld_cyc_q.size(); sb = sd_cyc_q.size();
        song = 0;
        play = 1'b1;
        wait_loads(b + 3, 100, ok);
        l = ld_cyc_q[b+2];
        cancel_gen++;
        song = 1;
        new_song = 1'b1;
        tick();
        new_song = 1'b0;
        song = 2;
        exp_a = {SB'(1), IB'(0)};
        n_checks++;
        if (rom_addr !== exp_a) begin
            n_fail++;
            $display("FAIL newsong_addr: got %0h required %0h", rom_addr, exp_a);
        end
        build_expected(1);
        wait_loads(b + 4, 50, ok);
        n_checks++;
        if (!ok || ld_cyc_q[b+3] !== l + 4 || sd_cyc_q.size() !== sb) begin
            n_fail++;
            $display("FAIL newsong_restart: load edge %0d song_done x%0d required edge %0d x0", ld_cyc_q[b+3], sd_cyc_q.size() - sb, l + 4);
        end
        run_to_done(sb, 400, ok);
        n_checks++;
        if (!ok || ld_cyc_q.size() - b - 3 !== ex_note.size() || sd_cyc_q.size() - sb !== 1) begin
            n_fail++;
            $display("FAIL newsong_count: got %0d loads %0d dones required %0d 1", ld_cyc_q.size() - b - 3, sd_cyc_q.size() - sb, ex_note.size());
        end
        for (int k = 0; k < ex_note.size(); k++) begin
            n_checks++;
            if (ld_note_q[b+3+k] !== ex_note[k] || ld_dur_q[b+3+k] !== ex_dur[k] || ld_addr_q[b+3+k] !== {SB'(1), ex_idx[k]}) begin
                n_fail++;
                $display("FAIL newsong_load%0d: got (%0d,%0d)@%0h required (%0d,%0d)", k, ld_note_q[b+3+k], ld_dur_q[b+3+k],
                         ld_addr_q[b+3+k], ex_note[k], ex_dur[k]);
            end
        end
        tick();
    endtask

    task automatic test_random_songs();
        int b, sb, n;
        bit ok;
        rand_dly = 1'b1;
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 0 : int'($urandom_range(1, 20));
            for (int i = 0; i < SLOTS; i++) begin
                rom[2*SLOTS + i] = (i < n) ? rand_word() : {NW'($urandom), DW'(0)};
                if (i < n && $urandom_range(0, 3) == 0) rom[2*SLOTS + i][RW-1:DW] = '0;
            end
            build_expected(2);
            b = ld_cyc_q.size(); sb = sd_cyc_q.size();
            song = 2;
            play = 1'b1;
            run_to_done(sb, 600, ok);
            n_checks++;
            if (!ok || ld_cyc_q.size() - b !== ex_note.size() || sd_cyc_q.size() - sb !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d loads %0d dones required %0d 1", r, ld_cyc_q.size() - b, sd_cyc_q.size() - sb, ex_note.size());
            end
            for (int k = 0; k < ex_note.size(); k++) begin
                n_checks++;
                if (ld_note_q[b+k] !== ex_note[k] || ld_dur_q[b+k] !== ex_dur[k] || ld_addr_q[b+k] !== {SB'(2), ex_idx[k]}) begin
                    n_fail++;
                    $display("FAIL rand%0d_load%0d: got (%0d,%0d)@%0h required (%0d,%0d)", r, k, ld_note_q[b+k], ld_dur_q[b+k],
                             ld_addr_q[b+k], ex_note[k], ex_dur[k]);
                end
            end
            tick();
        end
        rand_dly = 1'b0;
    endtask

    task automatic test_full_song();
        int b, sb;
        bit ok;
        logic [AW-1:0] exp_a;
        rand_dly = 1'b1;
        for (int i = 0; i < SLOTS; i++) rom[3*SLOTS + i] = rand_word();
        build_expected(3);
        b = ld_cyc_q.size(); sb = sd_cyc_q.size();
        song = 3;
        play = 1'b1;
        run_to_done(sb, 2000, ok);
        n_checks++;
        if (!ok || ld_cyc_q.size() - b !== SLOTS || ex_note.size() !== SLOTS || sd_cyc_q.size() - sb !== 1) begin
            n_fail++;
            $display("FAIL full_count: got %0d loads %0d dones required %0d 1", ld_cyc_q.size() - b, sd_cyc_q.size() - sb, SLOTS);
        end
        for (int k = 0; k < ex_note.size(); k++) begin
            n_checks++;
            if (ld_note_q[b+k] !== ex_note[k] || ld_dur_q[b+k] !== ex_dur[k] || ld_addr_q[b+k] !== {SB'(3), ex_idx[k]}) begin
                n_fail++;
                $display("FAIL full_load%0d: got (%0d,%0d)@%0h required (%0d,%0d)", k, ld_note_q[b+k], ld_dur_q[b+k],
                         ld_addr_q[b+k], ex_note[k], ex_dur[k]);
            end
        end
        tick();
        exp_a = {SB'(3), IB'(0)};
        n_checks++;
        if (rom_addr !== exp_a || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wrap: got addr=%0h busy=%b required %0h 0", rom_addr, busy, exp_a);
        end
        rand_dly = 1'b0;
    endtask

    task automatic test_async_reset();
        int b, sb;
        bit ok;
        b = ld_cyc_q.size();
        song = 3;
        play = 1'b1;
        wait_loads(b + 2, 100, ok);
        tick();
        n_checks++;
        if (busy !== 1'b1 || load_new_note !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pre: got busy=%b load=%b required 1 0", busy, load_new_note);
        end
        #1;
        reset = 1'b1;
        play = 1'b0;
        #1;
        cancel_gen++;
        n_checks++;
        if ({load_new_note, song_done, busy} !== 3'b000 || {rom_addr, note_to_load, duration_to_load} !== '0) begin
            n_fail++;
            $display("FAIL areset_now: got load/done/busy=%b addr=%0h note=%0d dur=%0d required all 0",
                     {load_new_note, song_done, busy}, rom_addr, note_to_load, duration_to_load);
        end
        #3;
        reset = 1'b0;
        tick();
        tick();
        build_expected(0);
        b = ld_cyc_q.size(); sb = sd_cyc_q.size();
        song = 0;
        play = 1'b1;
        run_to_done(sb, 400, ok);
        n_checks++;
        if (!ok || ld_cyc_q.size() - b !== ex_note.size() || ld_addr_q[b] !== '0 || ld_note_q[b] !== ex_note[0]
            || ld_dur_q[b] !== ex_dur[0]) begin
            n_fail++;
            $display("FAIL areset_restart: got %0d loads first (%0d,%0d)@%0h required %0d loads (%0d,%0d)@0",
                     ld_cyc_q.size() - b, ld_note_q[b], ld_dur_q[b], ld_addr_q[b], ex_note.size(), ex_note[0], ex_dur[0]);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = rand_word();
        rom[0] = {6'd44, 6'd6};
        rom[1] = {6'd45, 6'd4};
        rom[2] = {6'd0, 6'd3};
        rom[3] = {6'd17, 6'd0};
        test_reset();
        test_basic();
        test_pause();
        test_new_song();
        test_random_songs();
        test_full_song();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
